oam_dma: RTL and testbench
==========================

# oam_dma

OAM DMA engine and memory-bus front end between the `sm83` core's external bus (`addr`/`d_out`/`write`/`d_in`) and system memory. A CPU write to register 0xFF46 copies 160 bytes from `{src, 8'h00}` to 0xFE00–0xFE9F. While a copy runs, the engine owns the main memory bus. The high page (0xFF00–0xFFFF) is split onto a separate bus so the CPU keeps HRAM/IO access during DMA.

## Interface
No parameters.
- `clk`  in  1  system clock; one bus cycle per clock
- `rst`  in  1  asynchronous, active-low reset
- `cpu_addr`  in  16  CPU address (from `sm83.addr`)
- `cpu_wdata`  in  8  CPU write data (from `sm83.d_out`)
- `cpu_write`  in  1  CPU write strobe, qualifies `cpu_addr` in the same cycle
- `cpu_rdata`  out  8  read data to the CPU (`sm83.d_in`), combinational
- `mem_addr`  out  16  main memory address, 0x0000–0xFEFF space
- `mem_wdata`  out  8  main memory write data
- `mem_write`  out  1  main memory write strobe
- `mem_rdata`  in  8  main memory read data, combinational, valid in the same cycle
- `hi_addr`  out  8  high-page offset (`cpu_addr[7:0]`)
- `hi_wdata`  out  8  high-page write data
- `hi_write`  out  1  high-page write strobe; never asserted for 0xFF46
- `hi_rdata`  in  8  high-page read data, combinational
- `dma_active`  out  1  high while state ≠ IDLE

## Operation
- Registers:
  - `src[7:0]`: the FF46 value, readable back.
  - `idx[7:0]`: 0..159.
  - `buf[7:0]`: the byte in flight.
  - `state`: IDLE, START, RD, WR.
- Address decode:
  - `cpu_addr[15:8]==8'hFF` selects the hi page. 0xFF46 is intercepted internally. All other hi-page addresses go to `hi_*` in every state.
  - Any other `cpu_addr` selects main memory.
- FF46 access:
  - Read returns `src`.
  - Write loads `src<=cpu_wdata`, `idx<=0`, `state<=START`. This happens in any state, so a write during a copy restarts it.
- State transitions:
  - IDLE: stays until an FF46 write.
  - START: one clock, bus still passes through, then → RD.
  - RD: `mem_addr={src,idx}`, `mem_write=0`, `buf<=mem_rdata` at the clock edge, then → WR.
  - WR: `mem_addr=16'hFE00+idx`, `mem_wdata=buf`, `mem_write=1`. If `idx==159`: → IDLE, `idx<=0`. Otherwise `idx<=idx+1`, → RD.
- In IDLE and START, the CPU's main-memory accesses pass through: `mem_addr=cpu_addr`, `mem_wdata=cpu_wdata`, `mem_write=cpu_write`, `cpu_rdata=mem_rdata`.
- In RD and WR, CPU main-memory reads return 8'hFF and CPU main-memory writes are dropped. CPU hi-page accesses are unaffected.
- Source arithmetic:
  - `{src,idx}` is a plain 16-bit concatenation with no clamping.
  - Sources 0xFE/0xFF are issued on `mem_addr` as-is.
  - `idx` never exceeds 159.
- An FF46 write landing in the same cycle as the final WR: the final write still occurs, and the restart wins (`state<=START`, `idx<=0`).

## Timing
- Reset values: `state=IDLE`, `src=8'h00`, `idx=0`, `buf=8'h00`, `dma_active=0`. While `rst` is low, `mem_write=0` and `hi_write=0` are forced.
- A reset asserted mid-copy aborts immediately. OAM is left partially written.
- FF46 write at edge N: START during cycle N+1, first RD in cycle N+2.
- Total copy: 1 + 320 clocks from the FF46 write. `dma_active` is high for exactly 321 cycles.
- Byte k: RD at cycle N+2+2k, WR at cycle N+3+2k. Last WR (k=159) is at cycle N+321, and IDLE resumes at N+322.
- All `cpu_rdata`/`mem_*`/`hi_*` outputs are combinational from state and the CPU bus. `dma_active` is a registered-state decode.

## Test plan
- Basic copy: preload 0xC000+i = i^8'h5A, write FF46=0xC0. Required: 0xFE00+i = i^8'h5A for i=0..159, 0xFEA0 untouched, `dma_active` high for 321 cycles, readback FF46 = 0xC0.
- Lockout: during the copy, CPU reads 0x0150 → 8'hFF and CPU writes 0xC100=0x77 are dropped (memory keeps its old value). A CPU write to 0xFF80=0x33 then read of 0xFF80 → 0x33 via `hi_*`.
- Restart: write FF46=0xC0, then at byte 50 write FF46=0xD0. Required: full 160 bytes from 0xD000 land in OAM, and `dma_active` drops 321 cycles after the second write.
- Final-cycle collision: FF46 write coincides with the WR of idx 159. Required: byte 159 is written, then START with `idx=0`.
- Reset mid-copy: `rst` low at byte 80. Required: state IDLE, FF46 reads 0x00, no further `mem_write`, and bytes 0–79 are written while 80–159 keep their old value.
- Passthrough: with no DMA active, CPU write 0xC000=0xA5 and read back 0xA5. 0xFF46 never appears on `hi_write`.

Source files
------------

// File: rtl/oam_dma_if.sv
// Bus bundle between the CPU external bus, main memory, the high page and the OAM DMA engine.
interface oam_dma_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_write;
    logic [7:0]  cpu_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_write;
    logic [7:0]  mem_rdata;
    logic [7:0]  hi_addr;
    logic [7:0]  hi_wdata;
    logic        hi_write;
    logic [7:0]  hi_rdata;
    logic        dma_active;

    // CPU, memory and high-page side of the bus
    modport master (
        output cpu_addr, cpu_wdata, cpu_write, mem_rdata, hi_rdata,
        input  cpu_rdata, mem_addr, mem_wdata, mem_write,
               hi_addr, hi_wdata, hi_write, dma_active
    );

    // DMA engine side of the bus
    modport slave (
        input  cpu_addr, cpu_wdata, cpu_write, mem_rdata, hi_rdata,
        output cpu_rdata, mem_addr, mem_wdata, mem_write,
               hi_addr, hi_wdata, hi_write, dma_active
    );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine: FF46 write copies 160 bytes from {src,00} to FE00-FE9F,
// owning main memory while the high page stays reachable by the CPU.
module oam_dma (
    input  logic      clk,
    input  logic      rst,
    oam_dma_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, START, RD, WR} state_t;

    state_t     state, state_nxt;
    logic [7:0] src, idx, data_buf;
    logic       hi_sel, reg_sel, reg_wr, busy, last;

    assign hi_sel  = (bus.cpu_addr[15:8] == 8'hFF);
    assign reg_sel = (bus.cpu_addr == 16'hFF46);
    assign reg_wr  = reg_sel & bus.cpu_write;
    assign busy    = (state == RD) || (state == WR);
    assign last    = (idx == 8'd159);

    assign bus.dma_active = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Source page, byte index and in-flight byte; an FF46 write always restarts the copy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src      <= 8'h00;
            idx      <= 8'd0;
            data_buf <= 8'h00;
        end else begin
            if (state == RD) data_buf <= bus.mem_rdata;
            if (reg_wr) begin
                src <= bus.cpu_wdata;
                idx <= 8'd0;
            end else if (state == WR) begin
                idx <= last ? 8'd0 : idx + 8'd1;
            end
        end
    end

    // Next state; a restart overrides whatever the copy would do next
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = IDLE;
            START:   state_nxt = RD;
            RD:      state_nxt = WR;
            WR:      state_nxt = last ? IDLE : RD;
            default: state_nxt = IDLE;
        endcase
        if (reg_wr) state_nxt = START;
    end

    // Bus steering: engine owns main memory in RD/WR, high page always passes through
    always_comb begin
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_write = bus.cpu_write & ~hi_sel;
        case (state)
            RD: begin
                bus.mem_addr  = {src, idx};
                bus.mem_write = 1'b0;
            end
            WR: begin
                bus.mem_addr  = 16'hFE00 + {8'h00, idx};
                bus.mem_wdata = data_buf;
                bus.mem_write = 1'b1;
            end
            default: ;
        endcase
        if (!rst) bus.mem_write = 1'b0;

        bus.hi_addr  = bus.cpu_addr[7:0];
        bus.hi_wdata = bus.cpu_wdata;
        bus.hi_write = rst & bus.cpu_write & hi_sel & ~reg_sel;

        if (reg_sel)     bus.cpu_rdata = src;
        else if (hi_sel) bus.cpu_rdata = bus.hi_rdata;
        else if (busy)   bus.cpu_rdata = 8'hFF;
        else             bus.cpu_rdata = bus.mem_rdata;
    end
endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma with behavioural main memory and high-page RAM.
module tb_oam_dma;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   mem_wr_cnt = 0;
    int   ff46_hi = 0;

    logic [7:0] mem [0:65535];
    logic [7:0] hi_mem [0:255];

    oam_dma_if bus();

    oam_dma dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr];
    assign bus.hi_rdata  = hi_mem[bus.hi_addr];

    // Memory models and write monitors
    always @(posedge clk) begin
        if (bus.mem_write) begin
            mem[bus.mem_addr] = bus.mem_wdata;
            mem_wr_cnt = mem_wr_cnt + 1;
        end
        if (bus.hi_write) begin
            hi_mem[bus.hi_addr] = bus.hi_wdata;
            if (bus.cpu_addr == 16'hFF46) ff46_hi = ff46_hi + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_write = 1'b1;
        @(posedge clk);
        #1 bus.cpu_write = 1'b0;
    endtask

    task automatic cpu_rd(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.cpu_addr  = a;
        bus.cpu_write = 1'b0;
        #1 d = bus.cpu_rdata;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (bus.dma_active && cyc < 2000) begin
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    initial begin
        logic [7:0] rd;
        int         cyc, bad, base;

        bus.cpu_addr  = 16'hC200;
        bus.cpu_wdata = 8'h00;
        bus.cpu_write = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) hi_mem[i] = 8'h00;
        for (int i = 0; i < 160; i++) begin
            mem[16'hC000 + i] = 8'(i) ^ 8'h5A;
            mem[16'hD000 + i] = 8'(i * 3 + 1);
            mem[16'hE000 + i] = 8'(i) ^ 8'hA5;
            mem[16'hB000 + i] = ~(8'(i) ^ 8'h5A);
        end
        mem[16'hFEA0] = 8'h3C;
        mem[16'hC100] = 8'h12;
        mem[16'h0150] = 8'h42;

        // Reset state with write strobes forced low
        #12;
        chk("rst_mem_write", bus.mem_write, 1'b0);
        bus.cpu_addr = 16'hFF80;
        #1 chk("rst_hi_write", bus.hi_write, 1'b0);
        chk("rst_active", bus.dma_active, 1'b0);
        bus.cpu_write = 1'b0;
        @(negedge clk) rst = 1'b1;
        cpu_rd(16'hFF46, rd);
        chk("rst_src", rd, 8'h00);

        // Passthrough while idle
        cpu_wr(16'hC200, 8'hA5);
        cpu_rd(16'hC200, rd);
        chk("pass_rd", rd, 8'hA5);
        cpu_rd(16'h1234, rd);
        chk("pass_addr", bus.mem_addr, 16'h1234);

        // Basic copy
        cpu_wr(16'hFF46, 8'hC0);
        wait_idle(cyc);
        chk("basic_cycles", cyc, 321);
        bad = 0;
        for (int i = 0; i < 160; i++) if (mem[16'hFE00 + i] !== (8'(i) ^ 8'h5A)) bad++;
        chk("basic_oam", bad, 0);
        chk("basic_fea0", mem[16'hFEA0], 8'h3C);
        cpu_rd(16'hFF46, rd);
        chk("basic_src", rd, 8'hC0);

        // CPU lockout from main memory, high page still usable
        cpu_wr(16'hFF46, 8'hC0);
        repeat (10) @(posedge clk);
        cpu_rd(16'h0150, rd);
        chk("lock_rd", rd, 8'hFF);
        cpu_wr(16'hC100, 8'h77);
        cpu_wr(16'hFF80, 8'h33);
        cpu_rd(16'hFF80, rd);
        chk("lock_hi", rd, 8'h33);
        wait_idle(cyc);
        chk("lock_done", bus.dma_active, 1'b0);
        chk("lock_drop", mem[16'hC100], 8'h12);
        cpu_rd(16'h0150, rd);
        chk("lock_after", rd, 8'h42);

        // Restart mid-copy
        cpu_wr(16'hFF46, 8'hC0);
        repeat (100) @(posedge clk);
        cpu_wr(16'hFF46, 8'hD0);
        wait_idle(cyc);
        chk("restart_cycles", cyc, 321);
        bad = 0;
        for (int i = 0; i < 160; i++) if (mem[16'hFE00 + i] !== 8'(i * 3 + 1)) bad++;
        chk("restart_oam", bad, 0);

        // FF46 write on the final WR
        cpu_wr(16'hFF46, 8'hE0);
        repeat (320) @(posedge clk);
        cpu_wr(16'hFF46, 8'hC0);
        chk("coll_active", bus.dma_active, 1'b1);
        chk("coll_last", mem[16'hFE9F], 8'h3A);
        @(posedge clk);
        #1 chk("coll_rd_addr", bus.mem_addr, 16'hC000);
        chk("coll_rd_we", bus.mem_write, 1'b0);
        wait_idle(cyc);
        chk("coll_cycles", cyc, 320);
        bad = 0;
        for (int i = 0; i < 160; i++) if (mem[16'hFE00 + i] !== (8'(i) ^ 8'h5A)) bad++;
        chk("coll_oam", bad, 0);

        // Reset at byte 80
        cpu_wr(16'hFF46, 8'hB0);
        repeat (161) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("mid_rst_we", bus.mem_write, 1'b0);
        chk("mid_rst_active", bus.dma_active, 1'b0);
        base = mem_wr_cnt;
        repeat (5) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        cpu_rd(16'hFF46, rd);
        chk("mid_rst_src", rd, 8'h00);
        repeat (400) @(posedge clk);
        #1 chk("mid_rst_nowr", mem_wr_cnt - base, 0);
        chk("mid_rst_idle", bus.dma_active, 1'b0);
        bad = 0;
        for (int i = 0; i < 80; i++) if (mem[16'hFE00 + i] !== ~(8'(i) ^ 8'h5A)) bad++;
        chk("mid_rst_low", bad, 0);
        bad = 0;
        for (int i = 80; i < 160; i++) if (mem[16'hFE00 + i] !== (8'(i) ^ 8'h5A)) bad++;
        chk("mid_rst_high", bad, 0);

        chk("ff46_on_hi", ff46_hi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
